// File: rtl/life_array_grid_pkg.sv
// Shared types and constants for the Life array: FSM states, B3/S23 rule
// thresholds and the live-neighbour counter.
package life_pkg;

  localparam int NCNT_W = 4;

  localparam logic [NCNT_W-1:0] BIRTH_N   = NCNT_W'(3);
  localparam logic [NCNT_W-1:0] SURVIVE_N = NCNT_W'(2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Count live cells among the eight neighbours (result 0..8).
  function automatic logic [NCNT_W-1:0] count_live(input logic [7:0] nbr);
    logic [NCNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + NCNT_W'(nbr[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/life_array_grid_if.sv
// Control/data bus of the Life array: row load, row readout, run control
// and status. The controller drives it through master, the grid is slave.
interface life_array_grid_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  localparam int RW = $clog2(ROWS);

  logic [COLS-1:0]  vali;
  logic [RW-1:0]    vali_selector;
  logic             write_enb;
  logic [RW-1:0]    valo_selector;
  logic [COLS-1:0]  valo;
  logic [COLS-1:0]  valo_prev;
  logic             step;
  logic             run_start;
  logic [GEN_W-1:0] run_len;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] generation;
  logic             stable;
  logic             extinct;

  modport master (
    output vali, vali_selector, write_enb, valo_selector, step, run_start, run_len,
    input  valo, valo_prev, busy, done, generation, stable, extinct
  );

  modport slave (
    input  vali, vali_selector, write_enb, valo_selector, step, run_start, run_len,
    output valo, valo_prev, busy, done, generation, stable, extinct
  );
endinterface

// File: rtl/life_array_grid_cell.sv
// One Life cell: B3/S23 next state from the cell and its eight neighbours.
module life_cell
  import life_pkg::*;
(
  input  logic       i_cell,
  input  logic [7:0] i_nbr,
  output logic       o_next
);
  logic [NCNT_W-1:0] w_cnt;

  // Born on exactly three neighbours, survive on two or three.
  always_comb begin
    w_cnt  = count_live(i_nbr);
    o_next = (w_cnt == BIRTH_N) | (i_cell & (w_cnt == SURVIVE_N));
  end
endmodule

// File: rtl/life_array_grid.sv
// ROWS x COLS Conway's Life array with row load/readout, single-step and
// counted runs, optional torus wrap and stable/extinct status. With WRAP=0
// the edge/corner inputs supply off-grid neighbours so arrays can be tiled.
module life_array_grid
  import life_pkg::*;
#(
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int WRAP           = 0,
  parameter int GEN_W          = 16,
  parameter int STOP_ON_STABLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  life_array_grid_if.slave bus,
  input  logic [COLS-1:0] ni,
  input  logic [COLS-1:0] si,
  input  logic [ROWS-1:0] wi,
  input  logic [ROWS-1:0] ei,
  input  logic            nwi,
  input  logic            nei,
  input  logic            sei,
  input  logic            swi,
  output logic [COLS-1:0] no,
  output logic [COLS-1:0] so,
  output logic [ROWS-1:0] wo,
  output logic [ROWS-1:0] eo,
  output logic            nwo,
  output logic            neo,
  output logic            seo,
  output logic            swo
);
  localparam int RW = $clog2(ROWS);
  localparam bit WR = (WRAP != 0);

  logic [ROWS-1:0][COLS-1:0] r_cur;
  logic [ROWS-1:0][COLS-1:0] r_prev;
  state_t                    r_state;
  logic [GEN_W-1:0]          r_cnt;
  logic [GEN_W-1:0]          r_gen;
  logic                      r_busy;
  logic                      r_done;

  logic [ROWS+1:0][COLS+1:0] w_pad;
  logic [ROWS-1:0][COLS-1:0] w_next;
  logic [RW-1:0]             w_rd_sel;
  logic                      w_same;

  // Surround the grid with a one-cell ring taken from the wrap or the edge inputs.
  always_comb begin
    // NOTE: every bit of w_pad is written on each pass, so no latch can be inferred.
    w_pad = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_pad[r+1][c+1] = r_cur[r][c];
    for (int c = 0; c < COLS; c++) begin
      w_pad[0][c+1]      = WR ? r_cur[ROWS-1][c] : ni[c];
      w_pad[ROWS+1][c+1] = WR ? r_cur[0][c]      : si[c];
    end
    for (int r = 0; r < ROWS; r++) begin
      w_pad[r+1][0]      = WR ? r_cur[r][COLS-1] : wi[r];
      w_pad[r+1][COLS+1] = WR ? r_cur[r][0]      : ei[r];
    end
    w_pad[0][0]           = WR ? r_cur[ROWS-1][COLS-1] : nwi;
    w_pad[0][COLS+1]      = WR ? r_cur[ROWS-1][0]      : nei;
    w_pad[ROWS+1][COLS+1] = WR ? r_cur[0][0]           : sei;
    w_pad[ROWS+1][0]      = WR ? r_cur[0][COLS-1]      : swi;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      life_cell u_cell (
        .i_cell (r_cur[r][c]),
        .i_nbr  ({w_pad[r][c],   w_pad[r][c+1],   w_pad[r][c+2],
                  w_pad[r+1][c],                  w_pad[r+1][c+2],
                  w_pad[r+2][c], w_pad[r+2][c+1], w_pad[r+2][c+2]}),
        .o_next (w_next[r][c])
      );
    end
  end

  assign w_same = (w_next == r_cur);

  // Grid registers plus IDLE/RUN control with registered busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the grid is a flop array rather than a RAM, so it is cleared with the rest of the state.
      r_cur   <= '0;
      r_prev  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gen   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.write_enb) begin
            r_cur[bus.vali_selector] <= bus.vali;
          end else if (bus.run_start) begin
            if (bus.run_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_cnt   <= bus.run_len;
            end
          end else if (bus.step) begin
            r_prev <= r_cur;
            r_cur  <= w_next;
            r_gen  <= r_gen + GEN_W'(1);
          end
        end
        RUN: begin
          r_prev <= r_cur;
          r_cur  <= w_next;
          r_gen  <= r_gen + GEN_W'(1);
          r_cnt  <= r_cnt - GEN_W'(1);
          if ((r_cnt == GEN_W'(1)) || ((STOP_ON_STABLE != 0) && w_same)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_sel       = bus.valo_selector;
  assign bus.valo       = r_cur[w_rd_sel];
  assign bus.valo_prev  = r_prev[w_rd_sel];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.generation = r_gen;
  assign bus.stable     = (r_cur == r_prev);
  assign bus.extinct    = (r_cur == '0);

  assign no  = r_cur[0];
  assign so  = r_cur[ROWS-1];
  assign nwo = r_cur[0][0];
  assign neo = r_cur[0][COLS-1];
  assign seo = r_cur[ROWS-1][COLS-1];
  assign swo = r_cur[ROWS-1][0];

  // Gather the left and right grid columns for the west/east outputs.
  always_comb begin
    wo = '0;
    eo = '0;
    for (int r = 0; r < ROWS; r++) begin
      wo[r] = r_cur[r][0];
      eo[r] = r_cur[r][COLS-1];
    end
  end
endmodule

// File: tb/tb_life_array_grid.sv
// Directed bench: a 16x16 edge-fed array (A) and an 8x8 torus (B).
module tb_life_array_grid;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  life_array_grid_if #(.ROWS(16), .COLS(16), .GEN_W(16)) if_a ();
  life_array_grid_if #(.ROWS(8),  .COLS(8),  .GEN_W(16)) if_b ();

  logic [15:0] ni_a, si_a, wi_a, ei_a, no_a, so_a, wo_a, eo_a;
  logic        nwi_a, nei_a, sei_a, swi_a, nwo_a, neo_a, seo_a, swo_a;
  logic [7:0]  ni_b, si_b, wi_b, ei_b, no_b, so_b, wo_b, eo_b;
  logic        nwi_b, nei_b, sei_b, swi_b, nwo_b, neo_b, seo_b, swo_b;

  life_array_grid #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(16), .STOP_ON_STABLE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a),
    .ni(ni_a), .si(si_a), .wi(wi_a), .ei(ei_a),
    .nwi(nwi_a), .nei(nei_a), .sei(sei_a), .swi(swi_a),
    .no(no_a), .so(so_a), .wo(wo_a), .eo(eo_a),
    .nwo(nwo_a), .neo(neo_a), .seo(seo_a), .swo(swo_a)
  );

  life_array_grid #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_W(16), .STOP_ON_STABLE(1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b),
    .ni(ni_b), .si(si_b), .wi(wi_b), .ei(ei_b),
    .nwi(nwi_b), .nei(nei_b), .sei(sei_b), .swi(swi_b),
    .no(no_b), .so(so_b), .wo(wo_b), .eo(eo_b),
    .nwo(nwo_b), .neo(neo_b), .seo(seo_b), .swo(swo_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_a.vali = '0; if_a.vali_selector = '0; if_a.write_enb = 0; if_a.valo_selector = '0;
    if_a.step = 0; if_a.run_start = 0; if_a.run_len = '0;
    if_b.vali = '0; if_b.vali_selector = '0; if_b.write_enb = 0; if_b.valo_selector = '0;
    if_b.step = 0; if_b.run_start = 0; if_b.run_len = '0;
    ni_a = '0; si_a = '0; wi_a = '0; ei_a = '0; nwi_a = 0; nei_a = 0; sei_a = 0; swi_a = 0;
    ni_b = '0; si_b = '0; wi_b = '0; ei_b = '0; nwi_b = 0; nei_b = 0; sei_b = 0; swi_b = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_a(input int row, input logic [15:0] val);
    if_a.write_enb = 1; if_a.vali_selector = 4'(row); if_a.vali = val;
    tick();
    if_a.write_enb = 0;
  endtask

  task automatic write_b(input int row, input logic [7:0] val);
    if_b.write_enb = 1; if_b.vali_selector = 3'(row); if_b.vali = val;
    tick();
    if_b.write_enb = 0;
  endtask

  task automatic step_a();
    if_a.step = 1; tick(); if_a.step = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    cmp_cnt++;
    if ({if_a.busy, if_a.done, if_a.stable, if_a.extinct} !== 4'b0011) begin
      err_cnt++;
      $display("FAIL reset_status: got busy/done/stable/extinct=%b want 0011",
               {if_a.busy, if_a.done, if_a.stable, if_a.extinct});
    end
    cmp_cnt++;
    if (if_a.generation !== 16'd0) begin
      err_cnt++; $display("FAIL reset_gen: got %0d want 0", if_a.generation);
    end
    cmp_cnt++;
    if ({no_a, so_a, wo_a, eo_a, nwo_a, neo_a, seo_a, swo_a, if_a.valo, if_a.valo_prev} !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: got %h want all zero",
                          {no_a, so_a, wo_a, eo_a, nwo_a, neo_a, seo_a, swo_a});
    end
  endtask

  task automatic test_blinker();
    logic [15:0] exp;
    write_a(7, 16'h0380);
    if_a.valo_selector = 4'd7; #1;
    cmp_cnt++;
    if (if_a.valo !== 16'h0380) begin
      err_cnt++; $display("FAIL blink_write: got %h want 0380", if_a.valo);
    end
    step_a();
    for (int r = 0; r < 16; r++) begin
      exp = (r >= 6 && r <= 8) ? 16'h0100 : 16'h0000;
      if_a.valo_selector = 4'(r); #1;
      cmp_cnt++;
      if (if_a.valo !== exp) begin
        err_cnt++; $display("FAIL blink_gen1_row%0d: got %h want %h", r, if_a.valo, exp);
      end
    end
    if_a.valo_selector = 4'd7; #1;
    cmp_cnt++;
    if (if_a.valo_prev !== 16'h0380 || if_a.generation !== 16'd1) begin
      err_cnt++; $display("FAIL blink_prev: got prev=%h gen=%0d want 0380 1",
                          if_a.valo_prev, if_a.generation);
    end
    step_a();
    for (int r = 6; r <= 8; r++) begin
      exp = (r == 7) ? 16'h0380 : 16'h0000;
      if_a.valo_selector = 4'(r); #1;
      cmp_cnt++;
      if (if_a.valo !== exp) begin
        err_cnt++; $display("FAIL blink_gen2_row%0d: got %h want %h", r, if_a.valo, exp);
      end
    end
    cmp_cnt++;
    if (if_a.stable !== 1'b0 || if_a.generation !== 16'd2 || if_a.busy !== 1'b0) begin
      err_cnt++; $display("FAIL blink_status: got stable=%b gen=%0d busy=%b want 0 2 0",
                          if_a.stable, if_a.generation, if_a.busy);
    end
  endtask

  task automatic test_write_priority();
    if_a.step = 1;
    write_a(0, 16'h8001);
    if_a.step = 0;
    if_a.valo_selector = 4'd0; #1;
    cmp_cnt++;
    if (if_a.valo !== 16'h8001 || if_a.valo_prev !== 16'h0000 || if_a.generation !== 16'd2) begin
      err_cnt++; $display("FAIL write_step: got row=%h prev=%h gen=%0d want 8001 0000 2",
                          if_a.valo, if_a.valo_prev, if_a.generation);
    end
    if_a.run_start = 1; if_a.run_len = 16'd0;
    tick();
    if_a.run_start = 0;
    cmp_cnt++;
    if (if_a.done !== 1'b1 || if_a.busy !== 1'b0 || if_a.generation !== 16'd2) begin
      err_cnt++; $display("FAIL runlen0: got done=%b busy=%b gen=%0d want 1 0 2",
                          if_a.done, if_a.busy, if_a.generation);
    end
    tick();
    cmp_cnt++;
    if (if_a.done !== 1'b0) begin
      err_cnt++; $display("FAIL runlen0_pulse: got done=%b want 0", if_a.done);
    end
  endtask

  task automatic test_block_stop();
    int cyc;
    do_reset();
    write_a(3, 16'h0018);
    write_a(4, 16'h0018);
    if_a.run_start = 1; if_a.run_len = 16'd100;
    tick();
    if_a.run_start = 0;
    cmp_cnt++;
    if (if_a.busy !== 1'b1) begin
      err_cnt++; $display("FAIL block_busy: got %b want 1", if_a.busy);
    end
    cyc = 0;
    do begin tick(); cyc++; end while (!if_a.done && cyc < 200);
    cmp_cnt++;
    if (cyc !== 1 || if_a.done !== 1'b1) begin
      err_cnt++; $display("FAIL block_cycles: got %0d done=%b want 1 1", cyc, if_a.done);
    end
    if_a.valo_selector = 4'd4; #1;
    cmp_cnt++;
    if (if_a.stable !== 1'b1 || if_a.generation !== 16'd1 || if_a.busy !== 1'b0 ||
        if_a.valo !== 16'h0018) begin
      err_cnt++; $display("FAIL block_end: got stable=%b gen=%0d busy=%b row4=%h want 1 1 0 0018",
                          if_a.stable, if_a.generation, if_a.busy, if_a.valo);
    end
  endtask

  task automatic test_edge_inputs();
    do_reset();
    ni_a = 16'h0007;
    step_a();
    ni_a = '0;
    if_a.valo_selector = 4'd0; #1;
    cmp_cnt++;
    if (if_a.valo !== 16'h0002 || no_a !== 16'h0002) begin
      err_cnt++; $display("FAIL edge_ni: got row0=%h no=%h want 0002", if_a.valo, no_a);
    end
    do_reset();
    ni_b = 8'h07;
    if_b.step = 1; tick(); if_b.step = 0;
    ni_b = '0;
    if_b.valo_selector = 3'd0; #1;
    cmp_cnt++;
    if (if_b.valo !== 8'h00 || if_b.extinct !== 1'b1 || if_b.generation !== 16'd1) begin
      err_cnt++; $display("FAIL wrap_ni: got row0=%h extinct=%b gen=%0d want 00 1 1",
                          if_b.valo, if_b.extinct, if_b.generation);
    end
  endtask

  task automatic test_glider();
    int          cyc;
    logic [7:0]  exp;
    logic [7:0]  init_rows [8];
    init_rows = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    for (int r = 0; r < 3; r++) write_b(r, init_rows[r]);
    if_b.run_start = 1; if_b.run_len = 16'd32;
    tick();
    if_b.run_start = 0;
    cyc = 0;
    do begin tick(); cyc++; end while (!if_b.done && cyc < 200);
    cmp_cnt++;
    if (cyc !== 32 || if_b.done !== 1'b1 || if_b.busy !== 1'b0) begin
      err_cnt++; $display("FAIL glider_cycles: got %0d done=%b busy=%b want 32 1 0",
                          cyc, if_b.done, if_b.busy);
    end
    cmp_cnt++;
    if (if_b.generation !== 16'd32) begin
      err_cnt++; $display("FAIL glider_gen: got %0d want 32", if_b.generation);
    end
    for (int r = 0; r < 8; r++) begin
      exp = init_rows[r];
      if_b.valo_selector = 3'(r); #1;
      cmp_cnt++;
      if (if_b.valo !== exp) begin
        err_cnt++; $display("FAIL glider_row%0d: got %h want %h", r, if_b.valo, exp);
      end
    end
    tick();
    cmp_cnt++;
    if (if_b.done !== 1'b0) begin
      err_cnt++; $display("FAIL glider_done_pulse: got %b want 0", if_b.done);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    do_reset();
    write_a(7, 16'h0380);
    if_a.run_start = 1; if_a.run_len = 16'd10;
    tick();
    if_a.run_start = 0;
    tick(); tick();
    cmp_cnt++;
    if (if_a.busy !== 1'b1 || if_a.generation !== 16'd2) begin
      err_cnt++; $display("FAIL midrun_pre: got busy=%b gen=%0d want 1 2",
                          if_a.busy, if_a.generation);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp_cnt++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b0 || if_a.extinct !== 1'b1 ||
        if_a.generation !== 16'd0) begin
      err_cnt++; $display("FAIL midrun_reset: got busy=%b done=%b extinct=%b gen=%0d want 0 0 1 0",
                          if_a.busy, if_a.done, if_a.extinct, if_a.generation);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if_a.done) pulses++;
    end
    cmp_cnt++;
    if (pulses !== 0 || if_a.generation !== 16'd0) begin
      err_cnt++; $display("FAIL midrun_nodone: got pulses=%0d gen=%0d want 0 0",
                          pulses, if_a.generation);
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_write_priority();
    test_block_stop();
    test_edge_inputs();
    test_glider();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
